// File: rtl/seq_addsub.sv
// rtl/seq_addsub.sv - multi-cycle chunked ripple adder/subtractor with valid/ready handshakes
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operands/mode valid; accepted when in_ready is high
//   in_ready   high only while idle
//   a, b       WIDTH-bit operands
//   cin        carry-in (add) / borrow-in (subtract)
//   sub        0 = add, 1 = subtract
//   out_valid  result fields valid; held until out_ready
//   out_ready  consumer accepts the result
//   sum        WIDTH-bit result, modulo 2^WIDTH
//   cout       carry out of MSB (subtract: 1 = no borrow)
//   ovf        two's-complement signed overflow
//   zero       sum == 0
module seq_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             zero_r;
  logic             out_valid_r;

  logic [CHUNK-1:0] chunk_sum;
  logic             cy;
  logic             cy_msb;
  logic [WIDTH-1:0] sum_next;

  // Operands are shifted right one chunk per cycle, so the active chunk is
  // always the low CHUNK bits; the result is shifted in from the top.
  always_comb begin
    cy        = carry_r;
    cy_msb    = carry_r;
    chunk_sum = '0;
    for (int i = 0; i < CHUNK; i++) begin
      // full-adder cell; cy_msb ends up as the carry into the chunk's top bit
      cy_msb       = cy;
      chunk_sum[i] = a_r[i] ^ b_r[i] ^ cy;
      cy           = (a_r[i] & b_r[i]) | (cy & (a_r[i] ^ b_r[i]));
    end
  end

  assign sum_next = (sum_r >> CHUNK) | (WIDTH'(chunk_sum) << (WIDTH - CHUNK));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      a_r         <= '0;
      b_r         <= '0;
      carry_r     <= 1'b0;
      sum_r       <= '0;
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            // subtract is a + ~b + ~cin, so invert here and reuse the adder
            a_r     <= a;
            b_r     <= sub ? ~b : b;
            carry_r <= cin ^ sub;
            cnt     <= '0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          a_r     <= a_r >> CHUNK;
          b_r     <= b_r >> CHUNK;
          carry_r <= cy;
          sum_r   <= sum_next;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            cout_r      <= cy;
            ovf_r       <= cy ^ cy_msb;
            zero_r      <= (sum_next == '0);
            out_valid_r <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;
  assign zero      = zero_r;

endmodule

// File: doc/seq_addsub.md
Name: seq_addsub

Overview:
- Parametrised multi-cycle adder/subtractor with valid/ready handshakes on input and output.
- Processes CHUNK bits per clock through a CHUNK-bit ripple slice built from full-adder cells.
- The carry is registered between chunks, so the combinational carry chain is bounded to CHUNK bits regardless of WIDTH.
- Serves as the datapath arithmetic unit for wide operands where a full-width ripple chain would not meet timing.

Parameters:
- WIDTH, 16, operand and result width in bits.
- CHUNK, 4, bits processed per cycle. Must divide WIDTH; 1 <= CHUNK <= WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and mode are valid this cycle.
- in_ready  output  1  block can accept an operation; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for add, borrow-in for subtract.
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result fields are valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB (in subtract: 1 = no borrow).
- ovf  output  1  two's-complement signed overflow.
- zero  output  1  sum == 0.

Behaviour:
- Reset (synchronous, active-high): state = IDLE, in_ready = 1, out_valid = 0, sum = 0, cout = 0, ovf = 0, zero = 0, internal chunk counter = 0.
- Reset overrides every other input in the same cycle.
- Arithmetic:
  - sub = 0: {cout, sum} = a + b + cin.
  - sub = 1: {cout, sum} = a + ~b + ~cin, which equals a - b - cin mod 2^WIDTH.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = (sum == 0).
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch a, b (or ~b when sub = 1) and carry-in (cin, or ~cin when sub = 1). Clear the counter; next state = RUN.
- RUN:
  - in_ready = 0.
  - Each cycle, the chunk at bits [k*CHUNK +: CHUNK] is added with the registered carry.
  - The chunk result is written into sum, and the chunk carry-out is registered for chunk k+1.
  - After chunk N-1 (N = WIDTH/CHUNK): capture cout and ovf, compute zero, set out_valid = 1, next state = DONE.
- DONE:
  - out_valid = 1. sum, cout, ovf and zero are held stable.
  - in_valid is ignored.
  - On out_ready = 1: clear out_valid; next state = IDLE.
- Latency: out_valid rises N clock edges after the accepting edge (N = 4 at defaults; N = 1 for CHUNK = WIDTH).
- Throughput: at best one operation per N+2 cycles. in_ready is not re-asserted in the same cycle as the output handshake.
- Input fields are sampled only at the accepting edge; changes during RUN or DONE have no effect.
- sum contents are undefined-but-deterministic while out_valid = 0. Benches check sum only when out_valid = 1.
- Reset during RUN or DONE aborts the operation: no out_valid pulse, all outputs return to reset values the next cycle.
- out_ready asserted in IDLE or RUN is ignored.

Test Plan:
- Defaults; a=5000, b=6000, cin=0, sub=0 -> after 4 cycles: out_valid=1, sum=0x2AF8 (11000), cout=0, ovf=0, zero=0.
- a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0, zero=1; then a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- Subtract: a=5000, b=6000, cin=0, sub=1 -> sum=0xFC18 (-1000), cout=0, ovf=0; with a=6000, b=5000, cin=1 -> sum=999 (0x03E7), cout=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid, a and b -> out_valid, sum and flags are held unchanged and in_ready stays 0; then out_ready=1 -> out_valid=0 next cycle and in_ready=1.
- Assert rst for one cycle at the 2nd RUN cycle -> next cycle: state IDLE, in_ready=1, out_valid=0, sum=0, and no result is ever presented.
- Parameter sweep: CHUNK = 1, 4, 16 and WIDTH = 32 with 200 random operations each, compared against a behavioural model -> all fields match; latency equals WIDTH/CHUNK.
